load_store_seq: RTL and testbench
=================================

Name: load_store_seq

Overview:
- Multi-cycle sequencer that executes one ld/sd micro-operation at a time.
- Drives the register bank read/write ports (Ra, Rb, Rw, WE_Reg, dIN) and a data-memory request/ready handshake.
- Sits between instruction decode and the LoadStore datapath.
- Decode issues start plus operands; the block reports done/err.

Parameters:
- DATA_W, 64, register and memory data width.
- ADDR_W, 10, memory address width; effective address is truncated to its low ADDR_W bits.
- IMM_W, 12, signed offset width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue pulse; sampled only in IDLE
- op_st  in  1  0=load (ld rd,imm(rs1)), 1=store (sd rs2,imm(rs1))
- rs1  in  5  base register index
- rs2  in  5  store-data register index
- rd  in  5  load destination index
- imm  in  IMM_W  signed offset
- Ra  out  5  bank read port A index
- Rb  out  5  bank read port B index
- doutA  in  DATA_W  bank read A data, combinational from Ra
- doutB  in  DATA_W  bank read B data, combinational from Rb
- Rw  out  5  bank write index
- WE_Reg  out  1  bank write enable
- dIN  out  DATA_W  bank write data
- mem_addr  out  ADDR_W  memory address
- mem_re  out  1  read request
- mem_we  out  1  write request
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  load data, valid with mem_ready
- mem_ready  in  1  memory completes the current request this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse, coincident with done

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0. Any in-flight request is dropped; no bank write occurs.
- Registered outputs: all outputs are registered or decoded from state plus registered operands. Ra, Rb, Rw and mem_addr hold their values for the full duration of each state.
- IDLE:
  - start=1 latches op_st, rs1, rs2, rd, imm. Next state is READ.
  - start is ignored in every other state (no queueing).
- READ (1 cycle):
  - Ra=rs1, Rb=rs2.
  - At the end of the cycle, capture base=doutA and sdata=doutB.
  - Compute ea = base + sign_extend(imm), with 64-bit wrap-around; keep ea[ADDR_W-1:0].
  - Next state is MEM.
- MEM:
  - Load: mem_re=1.
  - Store: mem_we=1, mem_wdata=sdata.
  - mem_addr=ea throughout.
  - Stay in MEM until mem_ready=1, holding the request stable.
  - On mem_ready: a load captures mem_rdata and goes to WB; a store goes to DONE.
  - mem_ready seen outside MEM is ignored.
- WB (1 cycle, load only):
  - Rw=rd, dIN=captured data, WE_Reg=1.
  - If rd==0, WE_Reg stays 0 (x0 is never written).
  - Next state is DONE.
- DONE (1 cycle): done=1. Next state is IDLE, so a new start is accepted the following cycle.
- Latency with mem_ready=1 on the first MEM cycle, counting cycles after the start edge:
  - Load: 4 cycles (READ, MEM, WB, DONE).
  - Store: 3 cycles (READ, MEM, DONE).
- Each extra memory wait cycle adds one cycle.
- Store with rs1==rs2 is legal: base and data come from the same register.
- A load whose rd equals rs1 is legal: the base is captured before writeback.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined:
  - In READ, if ea[2:0]!=0, skip MEM and WB and go straight to DONE with err=1.
  - No memory request is issued and there is no bank write.
- Undefined: err is tied to 0 and ea is used as-is.

Decomposition:
- Package load_store_pkg:
  - State enum: IDLE, READ, MEM, WB, DONE.
  - Op encoding constants: OP_LD=0, OP_ST=1.
  - Register index width constant REG_IDX_W=5.
- Sub-module ls_addr_gen: combinational sign-extend and add, producing ea and the misalign flag.
- The FSM remains in load_store_seq.

Test Plan:
- Load x9 = mem[3]:
  - Stimulus: x0 holds 0, mem[3]=50, op_st=0, rs1=0, imm=3, rd=9, mem_ready=1.
  - Required: mem_addr=3 with mem_re for 1 cycle; WE_Reg=1, Rw=9, dIN=50 for 1 cycle; done on the 4th cycle after start.
- Store x9 to address 5:
  - Stimulus: x9=15, x5=0, op_st=1, rs1=5, rs2=9, imm=5, mem_ready delayed 3 cycles.
  - Required: mem_we held 4 cycles with mem_addr=5, mem_wdata=15; WE_Reg never asserted; done 6 cycles after start.
- Load to x0:
  - Stimulus: rd=0, otherwise as the first scenario.
  - Required: WE_Reg stays 0 throughout; done still pulses.
- Negative offset:
  - Stimulus: rs1 holds 16, imm=-8 (0xFF8).
  - Required: mem_addr=8.
- Reset mid-MEM:
  - Stimulus: drop rst_n while mem_re=1 and mem_ready=0.
  - Required: all outputs 0 immediately (asynchronously); state IDLE; no WE_Reg or done afterwards.
- With MISALIGN_CHECK_EN defined:
  - Stimulus: ea=3 (rs1 holds 0, imm=3).
  - Required: no mem_re or mem_we; done=1 and err=1 together on the 2nd cycle after start.
  - Without the macro, the same stimulus completes normally with err=0.

Source files
------------

// File: rtl/load_store_seq_pkg.sv
// Shared types and constants for the load/store sequencer.
package load_store_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic OP_LD = 1'b0;
    localparam logic OP_ST = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        MEM  = 3'd2,
        WB   = 3'd3,
        DONE = 3'd4
    } ls_state_e;

endpackage

// File: rtl/load_store_seq_if.sv
// Data-memory request/ready bus between the sequencer (master) and memory (slave).
interface load_store_seq_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_addr, mem_re, mem_we, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_re, mem_we, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/load_store_seq_addr_gen.sv
// Effective address generation: base + sign-extended offset, wrapped to DATA_W
// and truncated to ADDR_W. The misalign flag is only live when
// MISALIGN_CHECK_EN is defined; otherwise it is held at 0.
module ls_addr_gen #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10,
    parameter int IMM_W  = 12
) (
    input  logic [DATA_W-1:0] base,
    input  logic [IMM_W-1:0]  imm,
    output logic [ADDR_W-1:0] ea,
    output logic              misalign
);
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-ADDR_W-1:0] unused_sum_hi;

    // Full-width add so the wrap-around is exactly the 64-bit one.
    always_comb begin
        imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        sum      = base + imm_sext;
        ea       = sum[ADDR_W-1:0];
`ifdef MISALIGN_CHECK_EN
        misalign = |sum[2:0];
`else
        misalign = 1'b0;
`endif
    end

    // Bits above the memory address range are intentionally discarded.
    assign unused_sum_hi = sum[DATA_W-1:ADDR_W];
endmodule

// File: rtl/load_store_seq.sv
// Multi-cycle ld/sd sequencer between decode and the LoadStore datapath.
// Optional misaligned-address trap: MISALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for start; all outputs quiet
// READ  | Ra/Rb drive the bank; base and store data captured at cycle end
// MEM   | memory request held until mem_ready
// WB    | load data written to Rw (suppressed for x0)
// DONE  | one-cycle done pulse (err alongside on a misaligned trap)
module load_store_seq
    import load_store_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10,
    parameter int IMM_W  = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 op_st,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic [IMM_W-1:0]     imm,
    output logic [REG_IDX_W-1:0] Ra,
    output logic [REG_IDX_W-1:0] Rb,
    input  logic [DATA_W-1:0]    doutA,
    input  logic [DATA_W-1:0]    doutB,
    output logic [REG_IDX_W-1:0] Rw,
    output logic                 WE_Reg,
    output logic [DATA_W-1:0]    dIN,
    load_store_seq_if.master     mem,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    ls_state_e            state;
    logic                 op_q;
    logic [REG_IDX_W-1:0] rd_q;
    logic [IMM_W-1:0]     imm_q;

    logic [ADDR_W-1:0]    addr_q;
    logic                 re_q;
    logic                 we_q;
    logic [DATA_W-1:0]    wdata_q;

    logic [ADDR_W-1:0]    ag_ea;
    logic                 ag_misalign;

    ls_addr_gen #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .IMM_W  (IMM_W)
    ) u_addr_gen (
        .base     (doutA),
        .imm      (imm_q),
        .ea       (ag_ea),
        .misalign (ag_misalign)
    );

    assign mem.mem_addr  = addr_q;
    assign mem.mem_re    = re_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_wdata = wdata_q;

    // Sequencer FSM; every output is a register loaded on the transition into its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= OP_LD;
            rd_q    <= '0;
            imm_q   <= '0;
            Ra      <= '0;
            Rb      <= '0;
            Rw      <= '0;
            WE_Reg  <= 1'b0;
            dIN     <= '0;
            addr_q  <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            WE_Reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op_st;
                        rd_q  <= rd;
                        imm_q <= imm;
                        Ra    <= rs1;
                        Rb    <= rs2;
                        busy  <= 1'b1;
                        state <= READ;
                    end
                end
                READ: begin
                    Ra <= '0;
                    Rb <= '0;
                    if (ag_misalign) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        addr_q  <= ag_ea;
                        re_q    <= (op_q == OP_LD);
                        we_q    <= (op_q == OP_ST);
                        wdata_q <= (op_q == OP_ST) ? doutB : '0;
                        state   <= MEM;
                    end
                end
                MEM: begin
                    if (mem.mem_ready) begin
                        addr_q  <= '0;
                        re_q    <= 1'b0;
                        we_q    <= 1'b0;
                        wdata_q <= '0;
                        if (op_q == OP_LD) begin
                            Rw     <= rd_q;
                            dIN    <= mem.mem_rdata;
                            WE_Reg <= (rd_q != '0);
                            state  <= WB;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                WB: begin
                    Rw    <= '0;
                    dIN   <= '0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_seq.sv
// Directed self-checking bench for load_store_seq with a register-bank and
// memory model. Expectations follow MISALIGN_CHECK_EN when it is defined.
module tb_load_store_seq;
`ifdef MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op_st = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [11:0] imm = '0;
    logic [4:0]  Ra, Rb, Rw;
    logic [63:0] doutA, doutB, dIN;
    logic        WE_Reg, busy, done, err;

    logic [63:0] xreg [0:31];
    logic [63:0] dmem [0:1023];

    int n_checks = 0;
    int n_errors = 0;

    int wait_n = 0;
    int wait_ctr = 0;

    int re_cyc, we_cyc, wr_cyc, done_cyc, done_cnt;
    logic [9:0]  req_addr;
    logic [63:0] st_data, wr_data;
    logic [4:0]  wr_idx;
    logic        err_at_done;

    load_store_seq_if #(.ADDR_W(10), .DATA_W(64)) mem_bus ();

    load_store_seq #(.DATA_W(64), .ADDR_W(10), .IMM_W(12)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_st  (op_st),
        .rs1    (rs1),
        .rs2    (rs2),
        .rd     (rd),
        .imm    (imm),
        .Ra     (Ra),
        .Rb     (Rb),
        .doutA  (doutA),
        .doutB  (doutB),
        .Rw     (Rw),
        .WE_Reg (WE_Reg),
        .dIN    (dIN),
        .mem    (mem_bus),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    assign doutA = xreg[Ra];
    assign doutB = xreg[Rb];

    // Memory responder: ready after wait_n stall cycles of a live request.
    always @(negedge clk) begin
        if (mem_bus.mem_re || mem_bus.mem_we) begin
            mem_bus.mem_ready = (wait_ctr == wait_n);
            mem_bus.mem_rdata = dmem[mem_bus.mem_addr];
            wait_ctr = wait_ctr + 1;
        end else begin
            mem_bus.mem_ready = 1'b0;
            mem_bus.mem_rdata = '0;
            wait_ctr = 0;
        end
    end

    // Bank and memory write side.
    always @(posedge clk) begin
        if (WE_Reg) xreg[Rw] = dIN;
        if (mem_bus.mem_we && mem_bus.mem_ready) dmem[mem_bus.mem_addr] = mem_bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        re_cyc = 0; we_cyc = 0; wr_cyc = 0; done_cyc = 0; done_cnt = 0;
        req_addr = '0; st_data = '0; wr_data = '0; wr_idx = '0; err_at_done = 1'b0;
    endtask

    task automatic sample();
        if (mem_bus.mem_re) begin re_cyc++; req_addr = mem_bus.mem_addr; end
        if (mem_bus.mem_we) begin we_cyc++; req_addr = mem_bus.mem_addr; st_data = mem_bus.mem_wdata; end
        if (WE_Reg) begin wr_cyc++; wr_idx = Rw; wr_data = dIN; end
        if (done) done_cnt++;
    endtask

    task automatic run_op(input logic st, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] d, input logic [11:0] im, input int wn);
        clear_obs();
        wait_n = wn;
        @(negedge clk);
        op_st = st; rs1 = a1; rs2 = a2; rd = d; imm = im; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            sample();
            if (done) begin
                done_cyc = c;
                err_at_done = err;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) xreg[i] = '0;
        for (int i = 0; i < 1024; i++) dmem[i] = '0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_outs", {Ra, Rb, Rw, WE_Reg, done, err, mem_bus.mem_re, mem_bus.mem_we}, 0);
        chk("rst_data", dIN | mem_bus.mem_wdata | 64'(mem_bus.mem_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load x9 = mem[3]
        dmem[3] = 64'd50;
        run_op(1'b0, 5'd0, 5'd0, 5'd9, 12'd3, 0);
        chk("ld_done_cyc", done_cyc, MIS ? 2 : 4);
        chk("ld_err", err_at_done, MIS);
        chk("ld_re_cyc", re_cyc, MIS ? 0 : 1);
        chk("ld_addr", req_addr, MIS ? 0 : 3);
        chk("ld_wr_cyc", wr_cyc, MIS ? 0 : 1);
        chk("ld_rw", wr_idx, MIS ? 0 : 9);
        chk("ld_din", wr_data, MIS ? 0 : 50);
        chk("ld_x9", xreg[9], MIS ? 0 : 50);

        // Store x9 to address 5 with three wait cycles
        xreg[9] = 64'd15; xreg[5] = 64'd0;
        run_op(1'b1, 5'd5, 5'd9, 5'd0, 12'd5, 3);
        chk("st_done_cyc", done_cyc, MIS ? 2 : 6);
        chk("st_we_cyc", we_cyc, MIS ? 0 : 4);
        chk("st_addr", req_addr, MIS ? 0 : 5);
        chk("st_wdata", st_data, MIS ? 0 : 15);
        chk("st_wr_cyc", wr_cyc, 0);
        chk("st_re_cyc", re_cyc, 0);
        chk("st_mem5", dmem[5], MIS ? 0 : 15);

        // Load to x0
        run_op(1'b0, 5'd0, 5'd0, 5'd0, 12'd3, 0);
        chk("ldx0_wr_cyc", wr_cyc, 0);
        chk("ldx0_done_cyc", done_cyc, MIS ? 2 : 4);
        chk("ldx0_done_cnt", done_cnt, 1);
        chk("ldx0_x0", xreg[0], 0);

        // Negative offset, aligned: x3=16, imm=-8 -> 8; rd equals rs1
        xreg[3] = 64'd16; dmem[8] = 64'h1234_5678_9abc_def0;
        run_op(1'b0, 5'd3, 5'd0, 5'd3, 12'hFF8, 1);
        chk("neg_addr", req_addr, 8);
        chk("neg_re_cyc", re_cyc, 2);
        chk("neg_err", err_at_done, 0);
        chk("neg_done_cyc", done_cyc, 5);
        chk("neg_x3", xreg[3], 64'h1234_5678_9abc_def0);

        // Store with rs1 == rs2: x7 = 24 is both base and data
        xreg[7] = 64'd24;
        run_op(1'b1, 5'd7, 5'd7, 5'd0, 12'd0, 0);
        chk("same_addr", req_addr, 24);
        chk("same_wdata", st_data, 24);
        chk("same_done_cyc", done_cyc, 3);

        // Reset while a load is waiting in MEM
        clear_obs();
        wait_n = 30;
        @(negedge clk);
        op_st = 1'b0; rs1 = 5'd3; rd = 5'd11; imm = 12'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 10 && !mem_bus.mem_re; c++) @(negedge clk);
        chk("rstmid_re_seen", mem_bus.mem_re, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_req", {mem_bus.mem_re, mem_bus.mem_we, WE_Reg, done, err}, 0);
        chk("rstmid_addr", mem_bus.mem_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            sample();
        end
        chk("rstmid_no_wr", wr_cyc, 0);
        chk("rstmid_no_done", done_cnt, 0);
        chk("rstmid_x11", xreg[11], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end
endmodule
